// File: rtl/ddr3_dfi_rdcap_if.sv
// ---------------------------------------------------------------------------
// ddr3_dfi_rdcap_if : read-capture bus (DFI read side plus PHY capture side)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface ddr3_dfi_rdcap_if #(
    parameter int DFI_DQ_WIDTH = 32
) ();
    logic                    dfi_rden;
    logic                    dfi_rvld;
    logic                    dfi_last;
    logic [DFI_DQ_WIDTH-1:0] dfi_data;
    logic                    phy_rvld;
    logic [DFI_DQ_WIDTH-1:0] phy_data;

    // Controller/PHY side drives strobes and captured data
    modport master (
        output dfi_rden, phy_rvld, phy_data,
        input  dfi_rvld, dfi_last, dfi_data
    );

    modport slave (
        input  dfi_rden, phy_rvld, phy_data,
        output dfi_rvld, dfi_last, dfi_data
    );
endinterface

`default_nettype wire

// File: rtl/ddr3_dfi_rdcap.sv
// ---------------------------------------------------------------------------
// ddr3_dfi_rdcap : delays dfi_rden by the read latency and frames PHY data
// into bursts; DDR3_RDCAP_ALIGN_EN adds runtime latency measurement.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ddr3_dfi_rdcap #(
    parameter int DFI_DQ_WIDTH = 32,
    parameter int BURST_BEATS  = 4,
    parameter int RD_LATENCY   = 6,
    parameter int MAX_LATENCY  = 15
) (
    input  wire logic                               clock,
    input  wire logic                               arst_n,
    input  wire logic                               dfi_align_i,
    output logic                                    dfi_calib_o,
    ddr3_dfi_rdcap_if.slave                         rd_if,
    output logic [$clog2(MAX_LATENCY+1)-1:0]        lat_o,
    output logic                                    err_o
);
    localparam int LB = $clog2(MAX_LATENCY + 1);
    localparam int CB = $clog2(BURST_BEATS);

    logic [MAX_LATENCY-1:0]  dl_q;
    logic [LB-1:0]           lat_q;
    logic                    rden_in;
    logic                    bst;
    logic                    act_q;
    logic [CB-1:0]           cnt_q;
    logic [DFI_DQ_WIDTH-1:0] phy_q;
    logic                    rvld_q;
    logic                    last_q;
    logic [DFI_DQ_WIDTH-1:0] data_q;
    logic                    ovl_q;
    logic                    err_q;
    logic                    calib_q;
    logic                    fwd_block;
    logic                    cal_err;

    always_comb begin
        bst = 1'b0;
        if (lat_q != '0) bst = dl_q[lat_q - LB'(1)];
    end

    assign rden_in = rd_if.dfi_rden && !fwd_block;

    // Overlap error is delayed one stage so it lines up with the first beat of the new burst
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            dl_q   <= '0;
            phy_q  <= '0;
            act_q  <= 1'b0;
            cnt_q  <= '0;
            rvld_q <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
            ovl_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            dl_q  <= {dl_q[MAX_LATENCY-2:0], rden_in};
            phy_q <= rd_if.phy_data;
            ovl_q <= bst && act_q && (cnt_q != '0);
            err_q <= err_q | ovl_q | cal_err;
            if (act_q && !fwd_block) begin
                rvld_q <= 1'b1;
                last_q <= (cnt_q == '0);
                data_q <= phy_q;
            end else begin
                rvld_q <= 1'b0;
                last_q <= 1'b0;
            end
            if (bst) begin
                act_q <= 1'b1;
                cnt_q <= CB'(BURST_BEATS - 1);
            end else if (act_q) begin
                if (cnt_q == '0) act_q <= 1'b0;
                else             cnt_q <= cnt_q - CB'(1);
            end
        end
    end

`ifdef DDR3_RDCAP_ALIGN_EN
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

    localparam logic [LB:0] MAXV = (LB+1)'(MAX_LATENCY);

    state_t        state_q, state_d;
    logic          align_q;
    logic [LB-1:0] mcnt_q, mcnt_d;
    logic [LB-1:0] lat_d;
    logic          calib_d;
    logic [LB:0]   mnext;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            align_q <= 1'b0;
            mcnt_q  <= '0;
            lat_q   <= LB'(RD_LATENCY);
            calib_q <= 1'b0;
        end else begin
            state_q <= state_d;
            align_q <= dfi_align_i;
            mcnt_q  <= mcnt_d;
            lat_q   <= lat_d;
            calib_q <= calib_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        lat_d   = lat_q;
        calib_d = calib_q;
        cal_err = 1'b0;
        mnext   = {1'b0, mcnt_q} + (LB+1)'(1);
        case (state_q)
            S_IDLE: begin
                if (dfi_align_i && !align_q) begin
                    state_d = S_ARM;
                    calib_d = 1'b0;
                end
            end
            S_ARM: begin
                if (!dfi_align_i) begin
                    state_d = S_IDLE;
                end else if (rd_if.dfi_rden) begin
                    state_d = S_MEAS;
                    mcnt_d  = '0;
                end
            end
            S_MEAS: begin
                if (!dfi_align_i) begin
                    state_d = S_IDLE;
                end else begin
                    mcnt_d = mcnt_q + LB'(1);
                    if (rd_if.phy_rvld && (mnext <= MAXV)) begin
                        lat_d   = mnext[LB-1:0];
                        calib_d = 1'b1;
                        state_d = S_DONE;
                    end else if (mnext > MAXV) begin
                        cal_err = 1'b1;
                        state_d = S_ARM;
                    end
                end
            end
            default: begin
                if (!dfi_align_i) state_d = S_IDLE;
            end
        endcase
    end

    // Calibration reads neither enter the delay line nor reach the DFI
    assign fwd_block = (state_q == S_ARM) || (state_q == S_MEAS);
`else
    logic unused_cfg;
    assign unused_cfg = rd_if.phy_rvld ^ dfi_align_i;
    assign lat_q      = LB'(RD_LATENCY);
    assign fwd_block  = 1'b0;
    assign cal_err    = 1'b0;

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) calib_q <= 1'b0;
        else         calib_q <= 1'b1;
    end
`endif

    assign rd_if.dfi_rvld = rvld_q;
    assign rd_if.dfi_last = last_q;
    assign rd_if.dfi_data = data_q;
    assign dfi_calib_o    = calib_q;
    assign lat_o          = lat_q;
    assign err_o          = err_q;
endmodule

`default_nettype wire
